// File: rtl/dsp48a1_seq_pkg.sv
// dsp48a1_seq_pkg: sequencer states and DSP48A1 OPMODE field encodings
package dsp48a1_seq_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;
  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M = 2'b01;
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_P = 2'b10;
  localparam logic [1:0] Z_C = 2'b11;
  function automatic logic [7:0] opmode(input logic [1:0] z, input logic [1:0] x);
    return {4'b0000, z, x};
  endfunction
endpackage

// File: rtl/dsp48a1_opmode_delay.sv
// dsp48a1_opmode_delay: DEPTH-stage register chain that lags OPMODE behind its operands
module dsp48a1_opmode_delay #(
  parameter int DEPTH = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] pipe_q [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// dsp48a1_mac_sequencer: drives one DSP48A1 slice as P = bias + sum(A[i]*B[i])
module dsp48a1_mac_sequencer
  import dsp48a1_seq_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PIPE_LAT = 3,
  parameter int OPM_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [47:0]      bias,
  input  logic             bias_en,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [17:0]      dsp_d,
  output logic [47:0]      dsp_c,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p
);
  localparam int DW = $clog2(PIPE_LAT + 1);
  state_e           state_q;
  logic [CNT_W-1:0] remaining_q;
  logic [47:0]      bias_q;
  logic             bias_en_q, first_pending_q, dsp_rst_q;
  logic [17:0]      dsp_a_q, dsp_b_q;
  logic [7:0]       slot_op_q;
  logic [DW-1:0]    drain_q;
  logic             accept, last_slot;
  logic [1:0]       z_sel;
  assign in_ready  = state_q == ACCUM && remaining_q != '0;
  assign accept    = in_valid && in_ready;
  // len=0 still issues one slot so P is loaded with bias (or cleared)
  assign last_slot = remaining_q == '0 || (accept && remaining_q == CNT_W'(1));
  assign z_sel     = first_pending_q ? (bias_en_q ? Z_C : Z_ZERO) : Z_P;
  assign busy      = state_q != IDLE;
  assign res_valid = state_q == DONE;
  assign res_data  = dsp_p;
  assign dsp_ce    = state_q == ACCUM || state_q == DRAIN;
  assign dsp_rst   = dsp_rst_q;
  assign dsp_a     = dsp_a_q;
  assign dsp_b     = dsp_b_q;
  assign dsp_c     = bias_q;
  assign dsp_d     = '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q         <= IDLE;
      remaining_q     <= '0;
      bias_q          <= '0;
      bias_en_q       <= 1'b0;
      first_pending_q <= 1'b0;
      dsp_rst_q       <= 1'b1;
      dsp_a_q         <= '0;
      dsp_b_q         <= '0;
      slot_op_q       <= '0;
      drain_q         <= '0;
    end else begin
      dsp_rst_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q         <= IDLE;
        dsp_rst_q       <= 1'b1;
        first_pending_q <= 1'b0;
        slot_op_q       <= '0;
        dsp_a_q         <= '0;
        dsp_b_q         <= '0;
      end else
        case (state_q)
          IDLE:
            if (start) begin
              state_q         <= ACCUM;
              remaining_q     <= len;
              bias_q          <= bias;
              bias_en_q       <= bias_en;
              first_pending_q <= 1'b1;
            end
          ACCUM: begin
            slot_op_q <= opmode(z_sel, accept ? X_M : X_ZERO);
            if (accept) begin
              dsp_a_q         <= in_a;
              dsp_b_q         <= in_b;
              remaining_q     <= remaining_q - CNT_W'(1);
              first_pending_q <= 1'b0;
            end
            if (last_slot) begin
              state_q <= DRAIN;
              drain_q <= DW'(PIPE_LAT - 1);
            end
          end
          DRAIN: begin
            slot_op_q <= opmode(Z_P, X_ZERO);
            drain_q   <= drain_q - DW'(1);
            if (drain_q == '0) state_q <= DONE;
          end
          DONE: if (res_ready) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
    end
  dsp48a1_opmode_delay #(.DEPTH(OPM_DELAY), .W(8)) u_opm_delay (
    .clk(clk),
    .rst(rst),
    .d_i(slot_op_q),
    .q_o(dsp_opmode)
  );
endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// tb_dsp48a1_mac_sequencer: sequencer driving a behavioural DSP48A1, checked against plain MAC arithmetic
module tb_dsp48a1_mac_sequencer;
  logic        clk = 0, rst = 1, start = 0, bias_en = 0, abort = 0;
  logic [7:0]  len = 0;
  logic [47:0] bias = 0;
  logic        busy, in_valid = 0, in_ready, res_valid, res_ready = 0;
  logic [17:0] in_a = 0, in_b = 0, dsp_a, dsp_b, dsp_d;
  logic [47:0] res_data, dsp_c, dsp_p;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce, dsp_rst;
  int errors = 0, checks = 0;
  logic signed [17:0] ops_a [0:15], ops_b [0:15];

  always #5 clk = ~clk;

  dsp48a1_mac_sequencer #(.CNT_W(8), .PIPE_LAT(3), .OPM_DELAY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias), .bias_en(bias_en),
    .abort(abort), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
    .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );

  // DSP48A1 slice: A1/B1/C/M/P/OPMODE registers, sync reset over CE, pre-adder off
  logic signed [17:0] a1_r, b1_r;
  logic signed [35:0] m_r;
  logic [47:0] c_r, p_r, x_mux, z_mux;
  logic [7:0]  opm_r;
  always_comb begin
    x_mux = opm_r[1:0] == 2'b01 ? {{12{m_r[35]}}, m_r} :
            opm_r[1:0] == 2'b10 ? p_r :
            opm_r[1:0] == 2'b11 ? {dsp_d[11:0], a1_r, b1_r} : 48'd0;
    z_mux = opm_r[3:2] == 2'b10 ? p_r : opm_r[3:2] == 2'b11 ? c_r : 48'd0;
  end
  always @(posedge clk)
    if (dsp_rst) begin
      a1_r <= '0; b1_r <= '0; m_r <= '0; c_r <= '0; p_r <= '0; opm_r <= '0;
    end else if (dsp_ce) begin
      a1_r <= dsp_a; b1_r <= dsp_b; c_r <= dsp_c; opm_r <= dsp_opmode;
      m_r <= a1_r * b1_r;
      p_r <= z_mux + x_mux;
    end
  assign dsp_p = p_r;

  function automatic logic [47:0] ref_mac(input int n, input logic ben, input logic [47:0] b);
    logic signed [47:0] pr;
    logic [47:0] acc;
    acc = ben ? b : 48'd0;
    for (int i = 0; i < n; i++) begin
      pr = ops_a[i] * ops_b[i];
      acc = acc + pr;
    end
    return acc;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Starts a job and feeds pairs; returns once res_valid is up (or a bound expires)
  task automatic run_job(input int n, input logic ben, input logic [47:0] b, input int vmode,
                         output int lat, output bit rdy_seen);
    int idx, guard, k;
    bit acc;
    start = 1; len = 8'(n); bias = b; bias_en = ben;
    step();
    start = 0;
    idx = 0; guard = 0; rdy_seen = 0;
    while (idx < n && guard < 500) begin
      in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
      in_a = ops_a[idx]; in_b = ops_b[idx];
      acc = in_valid && in_ready;
      if (in_ready) rdy_seen = 1;
      step();
      guard++;
      if (acc) idx++;
    end
    in_valid = 0; in_a = 18'($urandom); in_b = 18'($urandom);
    if (idx < n) begin
      checks++; errors++;
      $display("FAIL accept_timeout: accepted %0d of %0d pairs", idx, n);
    end
    k = n > 0 ? 1 : 0;
    while (!res_valid && k < 50) begin
      if (in_ready) rdy_seen = 1;
      step();
      k++;
    end
    lat = k;
    if (!res_valid) begin
      checks++; errors++;
      $display("FAIL res_valid_timeout: no result after %0d cycles", k);
    end
  endtask

  task automatic consume();
    res_ready = 1;
    step();
    res_ready = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); len = 8'($urandom); bias = {16'($urandom), 32'($urandom)};
      bias_en = 1'($urandom); abort = 1'($urandom); in_valid = 1'($urandom);
      in_a = 18'($urandom); in_b = 18'($urandom); res_ready = 1'($urandom);
      step();
      checks++;
      if (res_valid !== 0 || in_ready !== 0 || dsp_ce !== 0 || dsp_rst !== 1 || busy !== 0 ||
          dsp_opmode !== 0 || dsp_c !== 0) begin
        errors++;
        $display("FAIL reset_state: rv=%b ir=%b ce=%b drst=%b busy=%b opm=%h c=%h want 0,0,0,1,0,0,0",
                 res_valid, in_ready, dsp_ce, dsp_rst, busy, dsp_opmode, dsp_c);
      end
    end
    rst = 0; start = 0; abort = 0; in_valid = 0; res_ready = 0; bias_en = 0; bias = 0;
    checks++;
    if (dsp_rst !== 1) begin
      errors++; $display("FAIL dsp_rst_before_edge: got %b want 1", dsp_rst);
    end
    step();
    checks++;
    if (dsp_rst !== 0 || busy !== 0 || in_ready !== 0) begin
      errors++; $display("FAIL dsp_rst_release: drst=%b busy=%b ir=%b want 0,0,0", dsp_rst, busy, in_ready);
    end
  endtask

  task automatic test_basic();
    int lat; bit rs;
    logic [47:0] exp;
    ops_a[0] = 20; ops_b[0] = 10; ops_a[1] = 5; ops_b[1] = 6;
    exp = ref_mac(2, 0, 0);
    run_job(2, 0, 48'd999, 0, lat, rs);
    checks++;
    if (res_data !== exp || exp !== 48'hE6) begin
      errors++; $display("FAIL basic_result: got %h want %h", res_data, exp);
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL basic_latency: got %0d want 4", lat);
    end
    consume();
  endtask

  task automatic test_bubbles();
    int lat; bit rs;
    logic [47:0] exp;
    exp = ref_mac(2, 1, 48'd350);
    run_job(2, 1, 48'd350, 1, lat, rs);
    checks++;
    if (res_data !== exp || exp !== 48'h244) begin
      errors++; $display("FAIL bubble_result: got %h want %h", res_data, exp);
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL bubble_latency: got %0d want 4", lat);
    end
    consume();
  endtask

  task automatic test_len0();
    int lat; bit rs, bad;
    run_job(0, 1, 48'd7, 0, lat, rs);
    checks++;
    if (res_data !== 48'd7) begin
      errors++; $display("FAIL len0_result: got %h want 7", res_data);
    end
    checks++;
    if (rs) begin
      errors++; $display("FAIL len0_in_ready: got pulse want none");
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (res_data !== 48'd7 || busy !== 1 || res_valid !== 1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL len0_hold: data=%h busy=%b rv=%b want 7,1,1", res_data, busy, res_valid);
    end
    consume();
  endtask

  task automatic test_abort();
    int n_acc, guard, lat, pulses;
    bit acc, rs, bad;
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = 18'($urandom); ops_b[i] = 18'($urandom);
    end
    start = 1; len = 4; bias = 48'd123; bias_en = 1;
    step();
    start = 0; n_acc = 0; guard = 0;
    while (n_acc < 2 && guard < 50) begin
      in_valid = 1; in_a = ops_a[n_acc]; in_b = ops_b[n_acc];
      acc = in_ready;
      step();
      guard++;
      if (acc) n_acc++;
    end
    in_a = ops_a[2]; in_b = ops_b[2];
    abort = 1;
    step();
    abort = 0; in_valid = 0;
    checks++;
    if (busy !== 0 || dsp_rst !== 1) begin
      errors++; $display("FAIL abort_next_cycle: busy=%b drst=%b want 0,1", busy, dsp_rst);
    end
    pulses = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (dsp_rst) pulses++;
      if (res_valid || busy) bad = 1;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL abort_rst_pulse: extra high cycles %0d want 0", pulses);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL abort_no_result: res_valid or busy seen after abort");
    end
    ops_a[0] = 3; ops_b[0] = 3;
    run_job(1, 0, 48'd0, 0, lat, rs);
    checks++;
    if (res_data !== 48'd9) begin
      errors++; $display("FAIL abort_next_job: got %h want 9", res_data);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat; bit rs;
    ops_a[0] = 2; ops_b[0] = 2;
    run_job(1, 0, 48'd0, 0, lat, rs);
    checks++;
    if (res_data !== 48'd4) begin
      errors++; $display("FAIL b2b_first: got %h want 4", res_data);
    end
    consume();
    ops_a[0] = 4; ops_b[0] = 4;
    run_job(1, 0, 48'd0, 0, lat, rs);
    checks++;
    if (res_data !== 48'd16) begin
      errors++; $display("FAIL b2b_second: got %h want 16", res_data);
    end
    consume();
  endtask

  task automatic test_random();
    int n, lat; bit rs;
    logic ben;
    logic [47:0] b, exp;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(0, 9);
      for (int i = 0; i < n; i++) begin
        ops_a[i] = 18'($urandom); ops_b[i] = 18'($urandom);
      end
      ben = 1'($urandom); b = {16'($urandom), 32'($urandom)};
      exp = ref_mac(n, ben, b);
      run_job(n, ben, b, 2, lat, rs);
      checks++;
      if (res_data !== exp) begin
        errors++; $display("FAIL random_result[%0d] len=%0d: got %h want %h", j, n, res_data, exp);
      end
      checks++;
      if (lat != 4) begin
        errors++; $display("FAIL random_latency[%0d]: got %0d want 4", j, lat);
      end
      repeat ($urandom_range(0, 3)) step();
      consume();
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_bubbles();
    test_len0();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
